// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source in-order result buffers, round-robin grant of up to
// WB_SIZE buffer heads per cycle onto a registered writeback bus, with redirect squash.
module wb_arbiter #(
    parameter int SRC_NUM    = 4,
    parameter int WB_SIZE    = 2,
    parameter int BUF_DEPTH  = 2,
    parameter int PREG_WIDTH = 7,
    parameter int XLEN       = 64,
    parameter int ROB_WIDTH  = 6
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [SRC_NUM-1:0]                src_valid,
    output logic [SRC_NUM-1:0]                src_ready,
    input  logic [SRC_NUM-1:0]                src_we,
    input  logic [SRC_NUM*PREG_WIDTH-1:0]     src_rd,
    input  logic [SRC_NUM*XLEN-1:0]           src_res,
    input  logic [SRC_NUM*(ROB_WIDTH+1)-1:0]  src_rob,
    input  logic                              redirect_en,
    input  logic [ROB_WIDTH:0]                redirect_rob,
    output logic [WB_SIZE-1:0]                wb_en,
    output logic [WB_SIZE-1:0]                wb_we,
    output logic [WB_SIZE*PREG_WIDTH-1:0]     wb_rd,
    output logic [WB_SIZE*XLEN-1:0]           wb_res,
    output logic [WB_SIZE*(ROB_WIDTH+1)-1:0]  wb_rob
);

    localparam int TAG_W = ROB_WIDTH + 1;
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int RR_W  = (SRC_NUM > 1) ? $clog2(SRC_NUM) : 1;

    function automatic logic is_younger(input logic [TAG_W-1:0] a, input logic [TAG_W-1:0] b);
        if (a[TAG_W-1] == b[TAG_W-1])
            return a[TAG_W-2:0] > b[TAG_W-2:0];
        else
            return a[TAG_W-2:0] < b[TAG_W-2:0];
    endfunction

    logic [PREG_WIDTH-1:0] in_rd  [SRC_NUM];
    logic [XLEN-1:0]       in_res [SRC_NUM];
    logic [TAG_W-1:0]      in_rob [SRC_NUM];

    logic                  buf_we_q  [SRC_NUM][BUF_DEPTH];
    logic [PREG_WIDTH-1:0] buf_rd_q  [SRC_NUM][BUF_DEPTH];
    logic [XLEN-1:0]       buf_res_q [SRC_NUM][BUF_DEPTH];
    logic [TAG_W-1:0]      buf_rob_q [SRC_NUM][BUF_DEPTH];

    logic [PTR_W-1:0] head_q  [SRC_NUM];
    logic [PTR_W-1:0] head_d  [SRC_NUM];
    logic [CNT_W-1:0] count_q [SRC_NUM];
    logic [CNT_W-1:0] count_d [SRC_NUM];
    logic [PTR_W-1:0] push_idx [SRC_NUM];
    logic [SRC_NUM-1:0] push_en;

    logic [RR_W-1:0]    rr_q, rr_d;
    logic [SRC_NUM-1:0] grant;
    logic [WB_SIZE-1:0] slot_vld;
    logic [RR_W-1:0]    slot_src [WB_SIZE];
    int                 scan;
    int                 n_grant;

    logic [WB_SIZE-1:0]    wb_en_q, wb_en_d;
    logic [WB_SIZE-1:0]    wb_we_q, wb_we_d;
    logic [PREG_WIDTH-1:0] wb_rd_q  [WB_SIZE];
    logic [PREG_WIDTH-1:0] wb_rd_d  [WB_SIZE];
    logic [XLEN-1:0]       wb_res_q [WB_SIZE];
    logic [XLEN-1:0]       wb_res_d [WB_SIZE];
    logic [TAG_W-1:0]      wb_rob_q [WB_SIZE];
    logic [TAG_W-1:0]      wb_rob_d [WB_SIZE];

    genvar gi;
    generate
        for (gi = 0; gi < SRC_NUM; gi++) begin : g_src
            assign in_rd[gi]     = src_rd[gi*PREG_WIDTH +: PREG_WIDTH];
            assign in_res[gi]    = src_res[gi*XLEN +: XLEN];
            assign in_rob[gi]    = src_rob[gi*TAG_W +: TAG_W];
            assign src_ready[gi] = ~rst && (count_q[gi] < CNT_W'(BUF_DEPTH));
        end
        for (gi = 0; gi < WB_SIZE; gi++) begin : g_wb
            assign wb_rd[gi*PREG_WIDTH +: PREG_WIDTH] = wb_rd_q[gi];
            assign wb_res[gi*XLEN +: XLEN]            = wb_res_q[gi];
            assign wb_rob[gi*TAG_W +: TAG_W]          = wb_rob_q[gi];
        end
    endgenerate

    assign wb_en = wb_en_q;
    assign wb_we = wb_we_q;

    // Round-robin scan over buffer heads only; slots are filled in scan order.
    always_comb begin
        grant    = '0;
        slot_vld = '0;
        rr_d     = rr_q;
        n_grant  = 0;
        scan     = 0;
        for (int w = 0; w < WB_SIZE; w++) slot_src[w] = '0;
        for (int k = 0; k < SRC_NUM; k++) begin
            scan = (int'(rr_q) + k) % SRC_NUM;
            if (count_q[scan] != '0 && n_grant < WB_SIZE) begin
                grant[scan]       = 1'b1;
                slot_src[n_grant] = RR_W'(scan);
                slot_vld[n_grant] = 1'b1;
                n_grant           = n_grant + 1;
                rr_d              = RR_W'((scan + 1) % SRC_NUM);
            end
        end
    end

    always_comb begin
        logic [RR_W-1:0]  sel;
        logic [PTR_W-1:0] hd;
        sel     = '0;
        hd      = '0;
        wb_en_d = '0;
        wb_we_d = '0;
        for (int w = 0; w < WB_SIZE; w++) begin
            sel         = slot_src[w];
            hd          = head_q[sel];
            wb_we_d[w]  = buf_we_q[sel][hd];
            wb_rd_d[w]  = buf_rd_q[sel][hd];
            wb_res_d[w] = buf_res_q[sel][hd];
            wb_rob_d[w] = buf_rob_q[sel][hd];
            wb_en_d[w]  = slot_vld[w] && !(redirect_en && is_younger(buf_rob_q[sel][hd], redirect_rob));
        end
    end

    // Entries are in program order per source, so redirect survivors form a prefix from head.
    always_comb begin
        logic [CNT_W-1:0] keep;
        logic             alive;
        logic             head_pop;
        logic [PTR_W-1:0] idx;
        keep     = '0;
        alive    = 1'b0;
        head_pop = 1'b0;
        idx      = '0;
        push_en  = '0;
        for (int s = 0; s < SRC_NUM; s++) begin
            keep = count_q[s];
            if (redirect_en) begin
                keep  = '0;
                alive = 1'b1;
                for (int k = 0; k < BUF_DEPTH; k++) begin
                    idx = head_q[s] + PTR_W'(k);
                    if (alive && (CNT_W'(k) < count_q[s]) && !is_younger(buf_rob_q[s][idx], redirect_rob))
                        keep = keep + 1'b1;
                    else
                        alive = 1'b0;
                end
            end
            head_pop    = grant[s] && (keep != '0);
            push_en[s]  = src_valid[s] && src_ready[s] && !(redirect_en && is_younger(in_rob[s], redirect_rob));
            push_idx[s] = head_q[s] + keep[PTR_W-1:0];
            head_d[s]   = head_q[s] + PTR_W'(head_pop);
            count_d[s]  = keep - CNT_W'(head_pop) + CNT_W'(push_en[s]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q    <= '0;
            wb_en_q <= '0;
            wb_we_q <= '0;
            for (int s = 0; s < SRC_NUM; s++) begin
                head_q[s]  <= '0;
                count_q[s] <= '0;
            end
            for (int w = 0; w < WB_SIZE; w++) begin
                wb_rd_q[w]  <= '0;
                wb_res_q[w] <= '0;
                wb_rob_q[w] <= '0;
            end
        end else begin
            rr_q    <= rr_d;
            wb_en_q <= wb_en_d;
            wb_we_q <= wb_we_d;
            for (int s = 0; s < SRC_NUM; s++) begin
                head_q[s]  <= head_d[s];
                count_q[s] <= count_d[s];
            end
            for (int w = 0; w < WB_SIZE; w++) begin
                wb_rd_q[w]  <= wb_rd_d[w];
                wb_res_q[w] <= wb_res_d[w];
                wb_rob_q[w] <= wb_rob_d[w];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < SRC_NUM; s++) begin
            if (push_en[s]) begin
                buf_we_q[s][push_idx[s]]  <= src_we[s];
                buf_rd_q[s][push_idx[s]]  <= in_rd[s];
                buf_res_q[s][push_idx[s]] <= in_res[s];
                buf_rob_q[s][push_idx[s]] <= in_rob[s];
            end
        end
    end

endmodule
